// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM states, SPI master
// register map and the register-port bus bundle driven by the sequencer.
package spi_xfer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GRANT,
        ST_CLR_STAT,
        ST_WR_SS,
        ST_SSO_ON,
        ST_WAIT_TRDY,
        ST_WR_TX,
        ST_WAIT_RRDY,
        ST_RD_RX,
        ST_SSO_OFF,
        ST_RESP
    } state_t;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_SSEL    = 3'd5;

    localparam logic [15:0] CTRL_SSO_ON  = 16'h0400;
    localparam logic [15:0] CTRL_SSO_OFF = 16'h0000;

    // One register-port access; held in a single register so every strobe is a flop output.
    typedef struct packed {
        logic        select;
        logic        read_n;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{select: 1'b0, read_n: 1'b1, write_n: 1'b1,
                                  addr: 3'd0, data: 16'h0000};

    function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_t b;
        b.select  = 1'b1;
        b.read_n  = 1'b1;
        b.write_n = 1'b0;
        b.addr    = addr;
        b.data    = data;
        return b;
    endfunction

    function automatic bus_t bus_read(input logic [2:0] addr);
        bus_t b;
        b.select  = 1'b1;
        b.read_n  = 1'b0;
        b.write_n = 1'b1;
        b.addr    = addr;
        b.data    = 16'h0000;
        return b;
    endfunction

endpackage

// File: rtl/spi_xfer_rr_arb.sv
// Two-way round-robin arbiter: when both request, the one not granted last wins.
module spi_xfer_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index of the last accepted requester; reset value 1 so requester 0 wins first.
    logic last_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Arbitrates two requesters and sequences full-duplex 1-4 byte transfers through
// the SPI master's register port, returning the captured MISO bytes.
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter logic [15:0] SS_MASK     = 16'h0001,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_len,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        spi_select,
    output logic        read_n,
    output logic        write_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    input  logic        dataavailable,
    input  logic        readyfordata
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC);

    state_t        state_reg;
    bus_t          bus_reg;
    logic [1:0]    acc_cnt_reg;
    logic [1:0]    owner_reg;
    logic [1:0]    len_reg;
    logic [1:0]    byte_cnt_reg;
    logic [31:0]   shift_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;
    logic [TW-1:0] timer_reg;
    logic [1:0]    req_ready_reg;
    logic [1:0]    rsp_valid_reg;
    logic [31:0]   rsp_rdata_reg;
    logic          rsp_err_reg;
    logic          busy_reg;

    logic [1:0]    grant;
    logic          accept;
    logic          in_access;
    logic          acc_done;
    logic          rx_hi_unused;

    logic [1:0]    len_slot   [2];
    logic [31:0]   wdata_slot [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign len_slot[gi]   = req_len[2*gi +: 2];
            assign wdata_slot[gi] = req_wdata[32*gi +: 32];
        end
    endgenerate

    assign accept       = (state_reg == ST_IDLE) && (req_valid != 2'b00);
    assign rx_hi_unused = ^data_to_cpu[15:8];

    spi_xfer_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .accept  (accept),
        .grant   (grant)
    );

    // Access states run a 3-cycle frame: two strobed cycles, then one idle gap.
    always_comb begin
        in_access = 1'b0;
        case (state_reg)
            ST_CLR_STAT, ST_WR_SS, ST_SSO_ON, ST_WR_TX, ST_RD_RX, ST_SSO_OFF: in_access = 1'b1;
            default: in_access = 1'b0;
        endcase
        acc_done = in_access && (acc_cnt_reg == 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            bus_reg       <= BUS_IDLE;
            acc_cnt_reg   <= 2'd0;
            owner_reg     <= 2'b00;
            len_reg       <= 2'd0;
            byte_cnt_reg  <= 2'd0;
            shift_reg     <= 32'h0;
            rdata_reg     <= 32'h0;
            err_reg       <= 1'b0;
            timer_reg     <= '0;
            req_ready_reg <= 2'b00;
            rsp_valid_reg <= 2'b00;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            if (in_access) begin
                acc_cnt_reg <= acc_done ? 2'd0 : acc_cnt_reg + 2'd1;
                if (acc_cnt_reg == 2'd1) begin
                    bus_reg <= BUS_IDLE;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_GRANT;
                        req_ready_reg <= grant;
                        owner_reg     <= grant;
                        busy_reg      <= 1'b1;
                        len_reg       <= len_slot[grant[1]];
                        shift_reg     <= wdata_slot[grant[1]];
                        rdata_reg     <= 32'h0;
                        byte_cnt_reg  <= 2'd0;
                        err_reg       <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    req_ready_reg <= 2'b00;
                    state_reg     <= ST_CLR_STAT;
                    bus_reg       <= bus_write(ADDR_STATUS, 16'h0000);
                end
                ST_CLR_STAT: begin
                    if (acc_done) begin
                        state_reg <= ST_WR_SS;
                        bus_reg   <= bus_write(ADDR_SSEL, SS_MASK);
                    end
                end
                ST_WR_SS: begin
                    if (acc_done) begin
                        state_reg <= ST_SSO_ON;
                        bus_reg   <= bus_write(ADDR_CONTROL, CTRL_SSO_ON);
                    end
                end
                ST_SSO_ON: begin
                    if (acc_done) begin
                        state_reg <= ST_WAIT_TRDY;
                        timer_reg <= TIMER_LOAD;
                    end
                end
                ST_WAIT_TRDY: begin
                    if (readyfordata) begin
                        state_reg <= ST_WR_TX;
                        bus_reg   <= bus_write(ADDR_TXDATA, {8'h00, shift_reg[31:24]});
                    end else if (timer_reg == '0) begin
                        state_reg <= ST_SSO_OFF;
                        err_reg   <= 1'b1;
                        bus_reg   <= bus_write(ADDR_CONTROL, CTRL_SSO_OFF);
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                ST_WR_TX: begin
                    if (acc_done) begin
                        state_reg <= ST_WAIT_RRDY;
                        shift_reg <= {shift_reg[23:0], 8'h00};
                        timer_reg <= TIMER_LOAD;
                    end
                end
                ST_WAIT_RRDY: begin
                    // Data arriving in the expiry cycle still wins over the timeout.
                    if (dataavailable) begin
                        state_reg <= ST_RD_RX;
                        bus_reg   <= bus_read(ADDR_RXDATA);
                    end else if (timer_reg == '0) begin
                        state_reg <= ST_SSO_OFF;
                        err_reg   <= 1'b1;
                        bus_reg   <= bus_write(ADDR_CONTROL, CTRL_SSO_OFF);
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                ST_RD_RX: begin
                    if (acc_cnt_reg == 2'd1) begin
                        rdata_reg <= {rdata_reg[23:0], data_to_cpu[7:0]};
                    end
                    if (acc_done) begin
                        if (byte_cnt_reg == len_reg) begin
                            state_reg <= ST_SSO_OFF;
                            bus_reg   <= bus_write(ADDR_CONTROL, CTRL_SSO_OFF);
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                            state_reg    <= ST_WAIT_TRDY;
                            timer_reg    <= TIMER_LOAD;
                        end
                    end
                end
                ST_SSO_OFF: begin
                    if (acc_done) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= owner_reg;
                        rsp_rdata_reg <= rdata_reg;
                        rsp_err_reg   <= err_reg;
                    end
                end
                ST_RESP: begin
                    rsp_valid_reg <= 2'b00;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    bus_reg   <= BUS_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_err       = rsp_err_reg;
    assign busy          = busy_reg;
    assign spi_select    = bus_reg.select;
    assign read_n        = bus_reg.read_n;
    assign write_n       = bus_reg.write_n;
    assign mem_addr      = bus_reg.addr;
    assign data_from_cpu = bus_reg.data;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: loopback SPI master model, access and
// response scoreboards, one task per scenario.
module tb_spi_xfer_ctrl;

    typedef struct packed {
        logic        rd;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    typedef struct packed {
        logic [1:0]  owner;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_len;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        spi_select;
    logic        read_n;
    logic        write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        dataavailable;
    logic        readyfordata;

    int checks = 0;
    int errors = 0;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    bit trdy_en = 1'b1;
    bit rrdy_en = 1'b1;

    spi_xfer_ctrl #(
        .SS_MASK     (16'h0001),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .spi_select    (spi_select),
        .read_n        (read_n),
        .write_n       (write_n),
        .mem_addr      (mem_addr),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Loopback SPI master: each TX byte comes back as RX data a few cycles later.
    initial begin : slave_model
        int  rx_cnt;
        bit  prev_sel;
        rx_cnt        = 0;
        prev_sel      = 1'b0;
        dataavailable = 1'b0;
        readyfordata  = 1'b0;
        data_to_cpu   = 16'h0000;
        forever begin
            @(negedge clk);
            readyfordata = trdy_en;
            if (!reset_n) begin
                rx_cnt        = 0;
                dataavailable = 1'b0;
            end else begin
                if (spi_select && !prev_sel && !write_n && mem_addr == 3'd1) begin
                    data_to_cpu = {8'hC3, data_from_cpu[7:0]};
                    rx_cnt      = 3;
                end else if (rx_cnt > 1) begin
                    rx_cnt--;
                end else if (rx_cnt == 1 && rrdy_en) begin
                    dataavailable = 1'b1;
                    rx_cnt        = 0;
                end
                if (spi_select && !prev_sel && !read_n && mem_addr == 3'd0) begin
                    dataavailable = 1'b0;
                end
            end
            prev_sel = spi_select;
        end
    end

    // Register-port monitor: strobe shape, stability, and expected access order.
    initial begin : acc_mon
        int   run;
        acc_t cur;
        acc_t e;
        run = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0;
            end else if (spi_select) begin
                checks++;
                if (!read_n && !write_n) begin
                    errors++;
                    $display("FAIL strobe_both_low: read_n=%b write_n=%b required not both 0", read_n, write_n);
                end
                if (run == 0) begin
                    cur.rd   = !read_n;
                    cur.addr = mem_addr;
                    cur.data = data_from_cpu;
                end else begin
                    checks++;
                    if (mem_addr !== cur.addr || data_from_cpu !== cur.data || read_n !== !cur.rd) begin
                        errors++;
                        $display("FAIL access_stable: addr=%0d data=%h rd_n=%b required addr=%0d data=%h rd=%b",
                                 mem_addr, data_from_cpu, read_n, cur.addr, cur.data, cur.rd);
                    end
                end
                run++;
            end else begin
                checks++;
                if (read_n !== 1'b1 || write_n !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_strobes: read_n=%b write_n=%b required 1/1", read_n, write_n);
                end
                if (run != 0) begin
                    checks++;
                    if (run != 2) begin
                        errors++;
                        $display("FAIL access_width: select high %0d cycles required 2", run);
                    end
                    checks++;
                    if (exp_acc.size() == 0) begin
                        errors++;
                        $display("FAIL access_unexpected: rd=%b addr=%0d data=%h required none", cur.rd, cur.addr, cur.data);
                    end else begin
                        e = exp_acc.pop_front();
                        if (e.rd !== cur.rd || e.addr !== cur.addr || (!e.rd && e.data !== cur.data)) begin
                            errors++;
                            $display("FAIL access_seq: rd=%b addr=%0d data=%h required rd=%b addr=%0d data=%h",
                                     cur.rd, cur.addr, cur.data, e.rd, e.addr, e.data);
                        end
                    end
                    run = 0;
                end
            end
        end
    end

    // Response monitor: pops the expected response; busy must drop with rsp_valid.
    initial begin : rsp_mon
        rsp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
            end else begin
                if (prev) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_after_rsp: busy=%b required 0", busy);
                    end
                end
                if (rsp_valid !== 2'b00) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_with_rsp: busy=%b required 1", busy);
                    end
                    checks++;
                    if (exp_rsp.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: rsp_valid=%b rdata=%h required none", rsp_valid, rsp_rdata);
                    end else begin
                        e = exp_rsp.pop_front();
                        if (rsp_valid !== e.owner || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                            errors++;
                            $display("FAIL rsp: valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                                     rsp_valid, rsp_rdata, rsp_err, e.owner, e.rdata, e.err);
                        end else begin
                            $display("rsp owner=%b rdata=%h err=%b", rsp_valid, rsp_rdata, rsp_err);
                        end
                    end
                end
                prev = (rsp_valid != 2'b00);
            end
        end
    end

    function automatic acc_t mk_acc(input logic rd, input logic [2:0] addr, input logic [15:0] data);
        acc_t a;
        a.rd   = rd;
        a.addr = addr;
        a.data = data;
        return a;
    endfunction

    // Expected register traffic and response for one transfer.
    task automatic push_xfer(input int idx, input logic [31:0] wd, input int n_tx, input int n_rx,
                             input bit finish, input bit err);
        logic [31:0] w;
        logic [31:0] rd;
        rsp_t        r;
        w  = wd;
        rd = 32'h0;
        exp_acc.push_back(mk_acc(1'b0, 3'd2, 16'h0000));
        exp_acc.push_back(mk_acc(1'b0, 3'd5, 16'h0001));
        exp_acc.push_back(mk_acc(1'b0, 3'd3, 16'h0400));
        for (int b = 0; b < n_tx; b++) begin
            exp_acc.push_back(mk_acc(1'b0, 3'd1, {8'h00, w[31:24]}));
            if (b < n_rx) begin
                exp_acc.push_back(mk_acc(1'b1, 3'd0, 16'h0000));
                rd = {rd[23:0], w[31:24]};
            end
            w = {w[23:0], 8'h00};
        end
        if (finish) begin
            exp_acc.push_back(mk_acc(1'b0, 3'd3, 16'h0000));
            r.owner = (idx == 0) ? 2'b01 : 2'b10;
            r.rdata = rd;
            r.err   = err;
            exp_rsp.push_back(r);
        end
    endtask

    task automatic issue(input int idx, input logic [1:0] len, input logic [31:0] wd);
        req_len[2*idx +: 2]    = len;
        req_wdata[32*idx +: 32] = wd;
        req_valid[idx]         = 1'b1;
    endtask

    task automatic wait_grant(output logic [1:0] g, output int n);
        n = 0;
        g = 2'b00;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (req_ready != 2'b00) break;
        end
        g = req_ready;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = !busy;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        exp_acc.delete();
        exp_rsp.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b err=%b busy=%b required 0", req_ready, rsp_valid, rsp_err, busy);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: %h required 0", rsp_rdata);
        end
        checks++;
        if ({spi_select, read_n, write_n, mem_addr, data_from_cpu} !== {1'b0, 1'b1, 1'b1, 3'd0, 16'h0}) begin
            errors++;
            $display("FAIL reset_bus: sel=%b rd_n=%b wr_n=%b addr=%0d data=%h required 0/1/1/0/0",
                     spi_select, read_n, write_n, mem_addr, data_from_cpu);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || spi_select !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b sel=%b required 0/0", busy, spi_select);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [1:0] g;
        int n;
        bit ok;
        trdy_en = 1'b1;
        rrdy_en = 1'b1;
        push_xfer(0, 32'hA53C_7710, 1, 1, 1'b1, 1'b0);
        issue(0, 2'd0, 32'hA53C_7710);
        wait_grant(g, n);
        req_valid[0] = 1'b0;
        checks++;
        if (g !== 2'b01 || n != 1) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b after %0d cycles required 01 after 1", g, n);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || spi_select !== 1'b1 || mem_addr !== 3'd2) begin
            errors++;
            $display("FAIL single_first_access: ready=%b sel=%b addr=%0d required 00/1/2", req_ready, spi_select, mem_addr);
        end
        wait_idle(ok);
        checks++;
        if (!ok || exp_acc.size() != 0 || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL single_done: idle=%b acc_left=%0d rsp_left=%0d required 1/0/0", ok, exp_acc.size(), exp_rsp.size());
        end
        $display("test_single done");
    endtask

    task automatic test_multi();
        logic [1:0] g;
        int n;
        bit ok;
        push_xfer(1, 32'h1234_5678, 4, 4, 1'b1, 1'b0);
        issue(1, 2'd3, 32'h1234_5678);
        wait_grant(g, n);
        req_valid[1] = 1'b0;
        checks++;
        if (g !== 2'b10) begin
            errors++;
            $display("FAIL multi_grant: req_ready=%b required 10", g);
        end
        wait_idle(ok);
        checks++;
        if (!ok || exp_acc.size() != 0 || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL multi_done: idle=%b acc_left=%0d rsp_left=%0d required 1/0/0", ok, exp_acc.size(), exp_rsp.size());
        end
        $display("test_multi done");
    endtask

    task automatic test_back_to_back();
        logic [1:0] g;
        int n;
        bit ok;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            push_xfer(0, 32'h6B00_0000, 1, 1, 1'b1, 1'b0);
            push_xfer(1, 32'h9E21_0000, 2, 2, 1'b1, 1'b0);
            issue(0, 2'd0, 32'h6B00_0000);
            issue(1, 2'd1, 32'h9E21_0000);
            wait_grant(g, n);
            req_valid[0] = 1'b0;
            checks++;
            if (g !== 2'b01) begin
                errors++;
                $display("FAIL arb_first round %0d: req_ready=%b required 01", round, g);
            end
            wait_idle(ok);
            wait_grant(g, n);
            req_valid[1] = 1'b0;
            checks++;
            if (g !== 2'b10 || n != 1) begin
                errors++;
                $display("FAIL arb_second round %0d: req_ready=%b after %0d required 10 after 1", round, g, n);
            end
            wait_idle(ok);
            checks++;
            if (!ok || exp_acc.size() != 0 || exp_rsp.size() != 0) begin
                errors++;
                $display("FAIL arb_done round %0d: idle=%b acc_left=%0d rsp_left=%0d", round, ok, exp_acc.size(), exp_rsp.size());
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        int n;
        int gap;
        bit ok;
        trdy_en = 1'b0;
        push_xfer(0, 32'h5A5A_0000, 0, 0, 1'b1, 1'b1);
        issue(0, 2'd1, 32'h5A5A_0000);
        wait_grant(g, n);
        req_valid[0] = 1'b0;
        n = 0;
        while (!(spi_select && mem_addr == 3'd3 && data_from_cpu == 16'h0400) && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (spi_select && n < 200) begin
            @(negedge clk);
            n++;
        end
        gap = 0;
        while (!spi_select && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        checks++;
        if (gap != 18 || mem_addr !== 3'd3 || data_from_cpu !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_gap: idle %0d cycles then addr=%0d data=%h required 18 then addr=3 data=0000",
                     gap, mem_addr, data_from_cpu);
        end
        wait_idle(ok);
        checks++;
        if (!ok || exp_acc.size() != 0 || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL timeout_done: idle=%b acc_left=%0d rsp_left=%0d required 1/0/0", ok, exp_acc.size(), exp_rsp.size());
        end
        trdy_en = 1'b1;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        int n;
        bit ok;
        rrdy_en = 1'b0;
        push_xfer(0, 32'hDEAD_BEEF, 1, 0, 1'b0, 1'b0);
        issue(0, 2'd3, 32'hDEAD_BEEF);
        wait_grant(g, n);
        req_valid[0] = 1'b0;
        n = 0;
        while ((exp_acc.size() != 0 || spi_select) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b required 1 before reset", busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, busy, spi_select, read_n, write_n, mem_addr, data_from_cpu}
            !== {2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'h0}) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b rdata=%h sel=%b rd_n=%b wr_n=%b required reset values",
                     busy, rsp_rdata, spi_select, read_n, write_n);
        end
        repeat (2) @(negedge clk);
        exp_acc.delete();
        reset_n = 1'b1;
        rrdy_en = 1'b1;
        push_xfer(0, 32'h0F1E_2D00, 3, 3, 1'b1, 1'b0);
        push_xfer(1, 32'h7700_0000, 1, 1, 1'b1, 1'b0);
        issue(0, 2'd2, 32'h0F1E_2D00);
        issue(1, 2'd0, 32'h7700_0000);
        wait_grant(g, n);
        req_valid[0] = 1'b0;
        checks++;
        if (g !== 2'b01) begin
            errors++;
            $display("FAIL mid_ptr_reset: req_ready=%b required 01", g);
        end
        wait_idle(ok);
        wait_grant(g, n);
        req_valid[1] = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || exp_acc.size() != 0 || exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL mid_recover: idle=%b acc_left=%0d rsp_left=%0d required 1/0/0", ok, exp_acc.size(), exp_rsp.size());
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_len   = 4'h0;
        req_wdata = 64'h0;
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
